// File: rtl/reg_scoreboard.sv
// Register scoreboard for the 5-stage pipeline: per-register in-flight write
// counters that stall ID on a pending source or a full destination counter.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_in,
  input  logic                id_freeze_in,
  input  logic [3:0]          id_src1_in,
  input  logic                id_instr_has_src1,
  input  logic [3:0]          id_src2_in,
  input  logic                id_two_src_in,
  input  logic                id_wb_en_in,
  input  logic [3:0]          id_wb_dest_in,
  input  logic                wb_en_in,
  input  logic [3:0]          wb_dest_in,
  input  logic                squash_en_in,
  input  logic [3:0]          squash_dest_in,
  output logic                hazard_out,
  output logic                issue_ack_out,
  output logic [NUM_REGS-1:0] pending_mask_out,
  output logic                err_underflow_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] count_flat;
  logic [NUM_REGS-1:0]            pending;
  logic [NUM_REGS-1:0]            underflow;
  logic                           err_reg;
  logic                           err_next;
  logic                           src1_busy;
  logic                           src2_busy;
  logic                           dest_full;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             inc;
      logic [1:0]       dec;
      logic [CNT_W:0]   sum;
      logic             under;

      always_comb begin
        inc   = issue_ack_out & id_wb_en_in & (id_wb_dest_in == 4'(gi));
        dec   = {1'b0, wb_en_in & (wb_dest_in == 4'(gi))}
              + {1'b0, squash_en_in & (squash_dest_in == 4'(gi))};
        sum   = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, inc};
        under = ((CNT_W+1)'(dec) > sum);
        // Retiring more writes than are tracked means a protocol error; clamp at zero.
        if (under) begin
          cnt_next = '0;
        end else begin
          cnt_next = CNT_W'(sum - (CNT_W+1)'(dec));
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign count_flat[gi] = cnt_reg;
      assign pending[gi]    = |cnt_reg;
      assign underflow[gi]  = under;
    end
  endgenerate

  assign src1_busy = id_instr_has_src1 & pending[id_src1_in];
  assign src2_busy = id_two_src_in & pending[id_src2_in];
  // A full counter blocks another writer so the count can never wrap.
  assign dest_full = id_valid_in & id_wb_en_in & (count_flat[id_wb_dest_in] == CNT_MAX);

  assign hazard_out        = src1_busy | src2_busy | dest_full;
  assign issue_ack_out     = ~rst & id_valid_in & ~id_freeze_in & ~hazard_out;
  assign pending_mask_out  = pending;
  assign err_underflow_out = err_reg;

  assign err_next = err_reg | (|underflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: the driver queues expected outputs per
// cycle, and a monitor on the falling edge pops and compares them.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid_in;
  logic        id_freeze_in;
  logic [3:0]  id_src1_in;
  logic        id_instr_has_src1;
  logic [3:0]  id_src2_in;
  logic        id_two_src_in;
  logic        id_wb_en_in;
  logic [3:0]  id_wb_dest_in;
  logic        wb_en_in;
  logic [3:0]  wb_dest_in;
  logic        squash_en_in;
  logic [3:0]  squash_dest_in;
  logic        hazard_out;
  logic        issue_ack_out;
  logic [15:0] pending_mask_out;
  logic        err_underflow_out;

  reg_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid_in       (id_valid_in),
    .id_freeze_in      (id_freeze_in),
    .id_src1_in        (id_src1_in),
    .id_instr_has_src1 (id_instr_has_src1),
    .id_src2_in        (id_src2_in),
    .id_two_src_in     (id_two_src_in),
    .id_wb_en_in       (id_wb_en_in),
    .id_wb_dest_in     (id_wb_dest_in),
    .wb_en_in          (wb_en_in),
    .wb_dest_in        (wb_dest_in),
    .squash_en_in      (squash_en_in),
    .squash_dest_in    (squash_dest_in),
    .hazard_out        (hazard_out),
    .issue_ack_out     (issue_ack_out),
    .pending_mask_out  (pending_mask_out),
    .err_underflow_out (err_underflow_out)
  );

  typedef struct {
    string       name;
    logic        hz;
    logic        ack;
    logic [15:0] mask;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  // Clock starts high so the first falling edge precedes the first rising edge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   bad;
      e   = exp_q.pop_front();
      bad = 0;
      checks_total++;
      if (hazard_out !== e.hz) begin
        $display("FAIL %s hazard_out got %0b want %0b", e.name, hazard_out, e.hz);
        bad++;
      end else checks_passed++;
      checks_total++;
      if (issue_ack_out !== e.ack) begin
        $display("FAIL %s issue_ack_out got %0b want %0b", e.name, issue_ack_out, e.ack);
        bad++;
      end else checks_passed++;
      checks_total++;
      if (pending_mask_out !== e.mask) begin
        $display("FAIL %s pending_mask_out got %04h want %04h", e.name, pending_mask_out, e.mask);
        bad++;
      end else checks_passed++;
      checks_total++;
      if (err_underflow_out !== e.err) begin
        $display("FAIL %s err_underflow_out got %0b want %0b", e.name, err_underflow_out, e.err);
        bad++;
      end else checks_passed++;
      $display("txn %-14s hz=%0b ack=%0b mask=%04h err=%0b %s", e.name, hazard_out,
               issue_ack_out, pending_mask_out, err_underflow_out, (bad == 0) ? "ok" : "bad");
    end
  end

  task automatic clr();
    id_valid_in = 0; id_freeze_in = 0;
    id_src1_in = 0; id_instr_has_src1 = 0;
    id_src2_in = 0; id_two_src_in = 0;
    id_wb_en_in = 0; id_wb_dest_in = 0;
    wb_en_in = 0; wb_dest_in = 0;
    squash_en_in = 0; squash_dest_in = 0;
  endtask

  task automatic wr(input logic [3:0] d);
    id_valid_in = 1; id_wb_en_in = 1; id_wb_dest_in = d;
  endtask

  task automatic cycle(input string nm, input logic hz, input logic ack,
                       input logic [15:0] mask, input logic err);
    exp_t e;
    e.name = nm; e.hz = hz; e.ack = ack; e.mask = mask; e.err = err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; clr(); wr(3);
    cycle("rst_hold0", 0, 0, 16'h0000, 0);
    cycle("rst_hold1", 0, 0, 16'h0000, 0);
    rst = 0;
    cycle("rel_issue_r3", 0, 1, 16'h0000, 0);
    // RAW on R3 held until the cycle after its retire.
    clr(); id_valid_in = 1; id_src1_in = 3; id_instr_has_src1 = 1;
    cycle("raw_r3", 1, 0, 16'h0008, 0);
    wb_en_in = 1; wb_dest_in = 3;
    cycle("raw_r3_wb", 1, 0, 16'h0008, 0);
    wb_en_in = 0;
    cycle("raw_r3_go", 0, 1, 16'h0000, 0);
    // Fill R5 to the counter limit.
    clr(); wr(5);
    cycle("r5_w1", 0, 1, 16'h0000, 0);
    cycle("r5_w2", 0, 1, 16'h0020, 0);
    cycle("r5_w3", 0, 1, 16'h0020, 0);
    cycle("r5_full", 1, 0, 16'h0020, 0);
    wb_en_in = 1; wb_dest_in = 5;
    cycle("r5_full_wb", 1, 0, 16'h0020, 0);
    wb_en_in = 0;
    cycle("r5_w4", 0, 1, 16'h0020, 0);
    cycle("r5_full_again", 1, 0, 16'h0020, 0);
    clr(); wb_en_in = 1; wb_dest_in = 5;
    cycle("r5_drain3", 0, 0, 16'h0020, 0);
    cycle("r5_drain2", 0, 0, 16'h0020, 0);
    cycle("r5_drain1", 0, 0, 16'h0020, 0);
    clr();
    cycle("r5_empty", 0, 0, 16'h0000, 0);
    // Same-cycle issue and retire of R7 nets to no change.
    wr(7);
    cycle("r7_w", 0, 1, 16'h0000, 0);
    wb_en_in = 1; wb_dest_in = 7;
    cycle("r7_w_wb", 0, 1, 16'h0080, 0);
    clr();
    cycle("r7_still1", 0, 0, 16'h0080, 0);
    wb_en_in = 1; wb_dest_in = 7;
    cycle("r7_retire", 0, 0, 16'h0080, 0);
    clr();
    cycle("r7_empty", 0, 0, 16'h0000, 0);
    // Double decrement of R2 underflows and latches the error.
    wr(2);
    cycle("r2_w", 0, 1, 16'h0000, 0);
    clr(); wb_en_in = 1; wb_dest_in = 2; squash_en_in = 1; squash_dest_in = 2;
    cycle("r2_under", 0, 0, 16'h0004, 0);
    clr();
    cycle("r2_err1", 0, 0, 16'h0000, 1);
    cycle("r2_err2", 0, 0, 16'h0000, 1);
    // Freeze blocks issue but not retire.
    wr(4);
    cycle("r4_w", 0, 1, 16'h0000, 1);
    wr(9); id_freeze_in = 1; wb_en_in = 1; wb_dest_in = 4;
    cycle("frz_r9_wb_r4", 0, 0, 16'h0010, 1);
    clr();
    cycle("frz_after", 0, 0, 16'h0000, 1);
    // Source-enable qualification on R10.
    wr(10);
    cycle("r10_w", 0, 1, 16'h0000, 1);
    clr(); id_valid_in = 1; id_src1_in = 10; id_src2_in = 10; id_two_src_in = 1;
    cycle("r10_src2", 1, 0, 16'h0400, 1);
    id_two_src_in = 0;
    cycle("r10_nosrc", 0, 1, 16'h0400, 1);
    clr(); squash_en_in = 1; squash_dest_in = 10;
    cycle("r10_squash", 0, 0, 16'h0400, 1);
    clr();
    cycle("r10_empty", 0, 0, 16'h0000, 1);
    // Mid-operation reset clears counts and the error at once.
    wr(1);
    cycle("r1_w", 0, 1, 16'h0000, 1);
    clr(); rst = 1;
    cycle("mid_rst", 0, 0, 16'h0000, 0);
    rst = 0;
    cycle("post_rst", 0, 0, 16'h0000, 0);
    wr(1);
    cycle("post_rst_w", 0, 1, 16'h0000, 0);
    clr();
    cycle("post_rst_r1", 0, 0, 16'h0002, 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks_total++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Sequential register scoreboard for the ARM 5-stage pipeline.
- Receives the writer side of the hazard protocol: destination writes entering the pipe at ID issue, and writes leaving it at WB retire or at squash.
- Keeps a per-register count of in-flight writes and raises a stall to the ID stage when a source operand has a pending write, or when the destination counter would overflow.
- Replaces per-stage destination comparison, so pipelines of any depth and variable-latency memory stages are covered.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked (R0-R15).
- CNT_W, 2, width of each in-flight counter; max outstanding writes per register is 2^CNT_W-1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- id_valid_in  input  1  ID holds a real instruction requesting issue.
- id_freeze_in  input  1  pipeline frozen (memory wait); blocks issue.
- id_src1_in  input  4  first source register.
- id_instr_has_src1  input  1  src1 is read.
- id_src2_in  input  4  second source register.
- id_two_src_in  input  1  src2 is read.
- id_wb_en_in  input  1  issuing instruction writes a register.
- id_wb_dest_in  input  4  its destination.
- wb_en_in  input  1  WB stage retires a register write this cycle.
- wb_dest_in  input  4  retired destination.
- squash_en_in  input  1  an in-flight writer is cancelled (condition failed or flushed past ID).
- squash_dest_in  input  4  cancelled destination.
- hazard_out  output  1  stall ID this cycle.
- issue_ack_out  output  1  issue accepted this cycle.
- pending_mask_out  output  NUM_REGS  bit r = count[r] != 0.
- err_underflow_out  output  1  sticky protocol error.

Behaviour:
- State: count[r], CNT_W bits, for each r; sticky err flag.
- Reset (async, rst=1): all counts 0, err 0. Outputs follow: hazard_out 0 (no pending), pending_mask_out 0, issue_ack_out 0 regardless of id_valid_in, err_underflow_out 0.
- Reset mid-operation: all state cleared immediately. In-flight writes are forgotten; the pipeline must be flushed together with the scoreboard.
- hazard_out is combinational from current state and ID inputs. It is 1 if any of the following holds:
  - id_instr_has_src1 & count[id_src1_in] != 0;
  - id_two_src_in & count[id_src2_in] != 0;
  - id_valid_in & id_wb_en_in & count[id_wb_dest_in] == max (structural full).
- Retire or squash in the same cycle does not clear hazard_out. The instruction issues next cycle at the earliest, giving a one-bubble minimum after WB.
- issue_ack_out = id_valid_in & ~id_freeze_in & ~hazard_out, combinational.
- Count update at each clk edge, per register r:
  - inc = issue_ack_out & id_wb_en_in & (id_wb_dest_in == r)
  - dec = (wb_en_in & wb_dest_in == r) + (squash_en_in & squash_dest_in == r), 0..2
  - count[r] <= count[r] + inc - dec
- Simultaneous inc and dec to the same register: net result applied; count unchanged for inc=1, dec=1.
- Underflow: if dec > count[r] + inc, count[r] saturates to 0 and err is set. err clears only on rst.
- Overflow cannot occur, because the structural-full stall blocks the issue.
- id_freeze_in forces issue_ack_out to 0 but does not block retire or squash updates.
- pending_mask_out is combinational from state: no ID dependence, updates the cycle after the edge.
- No latency beyond one clock from any event to the state change.

Test Plan:
- Reset with id_valid_in=1, id_wb_en_in=1, dest 3 held -> issue_ack_out 0, pending_mask_out 0x0000. After rst deasserts: ack 1, next cycle pending_mask_out 0x0008.
- Issue write R3 at cycle 0; at cycle 1, ID has src1=R3, has_src1=1 -> hazard_out 1 and ack 0 until the cycle after wb_en_in=1, wb_dest=3; then hazard_out 0 and mask bit 3 clears.
- Three successive writes to R5 with no retire (CNT_W=2) -> count 3; fourth write to R5 gets hazard_out 1. One retire of R5 -> the fourth write issues the following cycle, count stays 3.
- Same cycle: issue write R7 plus WB retire R7 with count[R7]=1 -> count remains 1, mask bit 7 stays 1, err 0.
- Count[R2]=1; wb_en_in and squash_en_in both target R2 in one cycle -> count 0, err_underflow_out 1 and stays 1 until rst.
- id_freeze_in=1 with a valid writer to R9 and wb retire R4 (count 1) -> ack 0, R9 unchanged, R4 count goes to 0.
